matrix_mem_ctrl: RTL and testbench
==================================

MATRIX_MEM_CTRL -- requirements
Module: matrix_mem_ctrl

Interface
REQ-001 Parameters (name, default, meaning): param_M, 4, rows of A and C; param_K, 4, inner dimension; param_N, 4, columns of B and C; DATA_WIDTH_INITIAL, 8, A/B element width; DATA_WIDTH_FINAL, DATA_WIDTH_INITIAL*2, C element width.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 host_we  in  1  host write strobe for A/B storage.
REQ-005 host_sel  in  1  write target: 0 = A (row-major), 1 = B (column-major).
REQ-006 host_waddr  in  $clog2(max(param_M*param_K, param_K*param_N))  flat write index.
REQ-007 host_wdata  in  DATA_WIDTH_INITIAL  write data.
REQ-008 host_raddr  in  $clog2(param_M*param_N)  C readback index, row-major.
REQ-009 host_rdata  out  DATA_WIDTH_FINAL  C readback data.
REQ-010 go  in  1  start request.
REQ-011 busy  out  1  high while in RUN.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 mac_start  out  1  compute enable to the MAC.
REQ-014 a_b_re  in  1  MAC read enable.
REQ-015 a_addr  in  $clog2(param_M*param_K); b_addr  in  $clog2(param_K*param_N)  MAC read addresses.
REQ-016 a_data  out  DATA_WIDTH_INITIAL; b_data  out  DATA_WIDTH_INITIAL  read data returned to the MAC.
REQ-017 c_we  in  1; c_addr  in  $clog2(param_M*param_N); c_data  in  DATA_WIDTH_FINAL  MAC result write port.
REQ-018 mac_done  in  1  MAC completion flag.

Function
REQ-019 Storage: A array of param_M*param_K entries, B array of param_K*param_N entries, C array of param_M*param_N entries; contents not reset.
REQ-020 FSM states are IDLE, RUN and DONE; after reset the state is IDLE.
REQ-021 Transitions: IDLE->RUN when go=1; RUN->DONE when mac_done=1; DONE->IDLE unconditionally after 1 cycle.
REQ-022 Output decode: mac_start=1 and busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-023 go in RUN or DONE is ignored; mac_done outside RUN is ignored, including the residual high cycle after mac_start drops.
REQ-024 Host A/B write commits on the edge where host_we=1 and state is IDLE; host_we in RUN or DONE is ignored.
REQ-025 An index out of range of the selected array is dropped without corrupting storage.
REQ-026 host_we and go in the same IDLE cycle: the write commits on that edge and RUN begins the next cycle.
REQ-027 MAC reads: on an edge with a_b_re=1, a_data <= A[a_addr] and b_data <= B[b_addr] (1-cycle latency); with a_b_re=0, a_data and b_data hold their values.
REQ-028 MAC writes: on an edge with c_we=1 in RUN, C[c_addr] <= c_data; c_we outside RUN is ignored.
REQ-029 Host readback: host_rdata <= C[host_raddr] every cycle (1-cycle latency, all states).
REQ-030 A MAC C write and a host read of the same index on the same edge return the old C value (read-before-write).
REQ-031 No arithmetic is performed in this block; C values are stored exactly as received (16-bit, already modulo 2^16).

Reset
REQ-032 While rstn=0: state=IDLE; mac_start, busy, done = 0; a_data, b_data, host_rdata = 0.
REQ-033 Reset asserted mid-RUN aborts immediately: mac_start drops asynchronously, no done pulse occurs, and the array contents are retained but undefined for partially written C.

Verification
REQ-034 Load A=identity, B=all 2, pulse go -> busy high until mac_done, one done pulse, then C[0..15] all read 2.
REQ-035 Load A and B all 255, run -> every C entry reads 63492 (260100 mod 65536).
REQ-036 Write A[0]=7 with host_we during RUN -> A[0] unchanged; a second go during RUN -> no second run and exactly one done pulse.
REQ-037 Pulse rstn low at cycle 10 of RUN -> mac_start, busy and done are 0 in the same cycle, and the FSM is in IDLE after release.
REQ-038 Drive host_we=1 and go=1 together with A[5]=3 -> A[5]=3 is used in the computation, and busy rises on the next cycle.
REQ-039 Hold mac_done high for 1 cycle after DONE -> no extra done pulse, and the FSM remains in IDLE.

Source files
------------

// File: rtl/matrix_mem_ctrl_if.sv
// Host and MAC side signals of the matrix memory controller.
// slave = the controller, master = host plus MAC engine.
interface matrix_mem_ctrl_if #(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
);
  localparam int SZ_A = param_M * param_K;
  localparam int SZ_B = param_K * param_N;
  localparam int SZ_C = param_M * param_N;
  localparam int SZ_H = (SZ_A > SZ_B) ? SZ_A : SZ_B;
  localparam int AW_A = (SZ_A > 1) ? $clog2(SZ_A) : 1;
  localparam int AW_B = (SZ_B > 1) ? $clog2(SZ_B) : 1;
  localparam int AW_C = (SZ_C > 1) ? $clog2(SZ_C) : 1;
  localparam int AW_H = (SZ_H > 1) ? $clog2(SZ_H) : 1;

  logic                          host_we;
  logic                          host_sel;
  logic [AW_H-1:0]               host_waddr;
  logic [DATA_WIDTH_INITIAL-1:0] host_wdata;
  logic [AW_C-1:0]               host_raddr;
  logic [DATA_WIDTH_FINAL-1:0]   host_rdata;
  logic                          go;
  logic                          busy;
  logic                          done;
  logic                          mac_start;
  logic                          a_b_re;
  logic [AW_A-1:0]               a_addr;
  logic [AW_B-1:0]               b_addr;
  logic [DATA_WIDTH_INITIAL-1:0] a_data;
  logic [DATA_WIDTH_INITIAL-1:0] b_data;
  logic                          c_we;
  logic [AW_C-1:0]               c_addr;
  logic [DATA_WIDTH_FINAL-1:0]   c_data;
  logic                          mac_done;

  modport slave (
    input  host_we, host_sel, host_waddr, host_wdata, host_raddr, go,
           a_b_re, a_addr, b_addr, c_we, c_addr, c_data, mac_done,
    output host_rdata, busy, done, mac_start, a_data, b_data
  );

  modport master (
    output host_we, host_sel, host_waddr, host_wdata, host_raddr, go,
           a_b_re, a_addr, b_addr, c_we, c_addr, c_data, mac_done,
    input  host_rdata, busy, done, mac_start, a_data, b_data
  );
endinterface

// File: rtl/matrix_mem_ctrl.sv
// A/B/C operand storage and run sequencing for an external MAC engine.
//   state  | meaning
//   S_IDLE | host may load A/B; waiting for go
//   S_RUN  | MAC enabled (mac_start/busy), C writes accepted; waiting for mac_done
//   S_DONE | one-cycle completion pulse, then back to S_IDLE
module matrix_mem_ctrl #(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
) (
  input logic              clk,
  input logic              rstn,
  matrix_mem_ctrl_if.slave bus
);
  localparam int SZ_A = param_M * param_K;
  localparam int SZ_B = param_K * param_N;
  localparam int SZ_C = param_M * param_N;
  localparam int SZ_H = (SZ_A > SZ_B) ? SZ_A : SZ_B;
  localparam int AW_A = (SZ_A > 1) ? $clog2(SZ_A) : 1;
  localparam int AW_B = (SZ_B > 1) ? $clog2(SZ_B) : 1;
  localparam int AW_H = (SZ_H > 1) ? $clog2(SZ_H) : 1;
  localparam logic [AW_H:0] LIM_A = SZ_A[AW_H:0];
  localparam logic [AW_H:0] LIM_B = SZ_B[AW_H:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        r_state;
  logic                          r_busy;
  logic                          r_mac_start;
  logic                          r_done;
  logic [DATA_WIDTH_INITIAL-1:0] r_mem_a [SZ_A];
  logic [DATA_WIDTH_INITIAL-1:0] r_mem_b [SZ_B];
  logic [DATA_WIDTH_FINAL-1:0]   r_mem_c [SZ_C];
  logic [DATA_WIDTH_INITIAL-1:0] r_a_data;
  logic [DATA_WIDTH_INITIAL-1:0] r_b_data;
  logic [DATA_WIDTH_FINAL-1:0]   r_host_rdata;

  logic w_host_wr;
  logic w_in_a;
  logic w_in_b;
  logic w_c_wr;

  assign w_host_wr = bus.host_we && (r_state == S_IDLE);
  assign w_in_a    = ({1'b0, bus.host_waddr} < LIM_A);
  assign w_in_b    = ({1'b0, bus.host_waddr} < LIM_B);
  assign w_c_wr    = bus.c_we && (r_state == S_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_mac_start <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.go) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_mac_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.mac_done) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_mac_start <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_mac_start <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // Array contents survive reset; out-of-range host indices are dropped.
  always_ff @(posedge clk) begin
    if (w_host_wr && !bus.host_sel && w_in_a)
      r_mem_a[bus.host_waddr[AW_A-1:0]] <= bus.host_wdata;
    if (w_host_wr && bus.host_sel && w_in_b)
      r_mem_b[bus.host_waddr[AW_B-1:0]] <= bus.host_wdata;
    if (w_c_wr)
      r_mem_c[bus.c_addr] <= bus.c_data;
  end

  // Readback samples C before any same-edge MAC write lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_data     <= '0;
      r_b_data     <= '0;
      r_host_rdata <= '0;
    end else begin
      if (bus.a_b_re) begin
        r_a_data <= r_mem_a[bus.a_addr];
        r_b_data <= r_mem_b[bus.b_addr];
      end
      r_host_rdata <= r_mem_c[bus.host_raddr];
    end
  end

  assign bus.busy       = r_busy;
  assign bus.mac_start  = r_mac_start;
  assign bus.done       = r_done;
  assign bus.a_data     = r_a_data;
  assign bus.b_data     = r_b_data;
  assign bus.host_rdata = r_host_rdata;
endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Directed + randomized bench; the bench plays both host and MAC engine.
module tb_matrix_mem_ctrl;
  localparam int M = 4, K = 4, N = 4;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   ref_a [M*K];
  int   ref_b [K*N];
  int   c_prev [M*N];

  matrix_mem_ctrl_if bus ();
  matrix_mem_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], A row-major, B column-major, mod 2^16.
  function automatic int c_ref(input int idx);
    int i, j, s;
    i = idx / N;
    j = idx % N;
    s = 0;
    for (int k = 0; k < K; k++) s += ref_a[i*K + k] * ref_b[j*K + k];
    return s % 65536;
  endfunction

  task automatic host_write(input bit sel, input int idx, input int val);
    bus.host_we    = 1'b1;
    bus.host_sel   = sel;
    bus.host_waddr = idx[3:0];
    bus.host_wdata = val[7:0];
    @(negedge clk);
    bus.host_we = 1'b0;
    if (sel) ref_b[idx] = val; else ref_a[idx] = val;
  endtask

  task automatic load_all();
    for (int x = 0; x < M*K; x++) host_write(1'b0, x, ref_a[x]);
    for (int x = 0; x < K*N; x++) host_write(1'b1, x, ref_b[x]);
  endtask

  task automatic start_run();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("busy_rise", bus.busy, 1);
    check("mac_start_rise", bus.mac_start, 1);
  endtask

  task automatic mac_run(input int extra_done);
    int acc, base;
    base = n_done;
    for (int idx = 0; idx < M*N; idx++) begin
      acc = 0;
      for (int k = 0; k < K; k++) begin
        bus.a_b_re = 1'b1;
        bus.a_addr = 4'((idx / N) * K + k);
        bus.b_addr = 4'((idx % N) * K + k);
        @(negedge clk);
        bus.a_b_re = 1'b0;
        check("a_data", bus.a_data, ref_a[(idx / N) * K + k]);
        check("b_data", bus.b_data, ref_b[(idx % N) * K + k]);
        acc += int'(bus.a_data) * int'(bus.b_data);
      end
      bus.c_we   = 1'b1;
      bus.c_addr = idx[3:0];
      bus.c_data = acc[15:0];
      @(negedge clk);
      bus.c_we = 1'b0;
    end
    check("busy_in_run", bus.busy, 1);
    check("no_done_in_run", n_done - base, 0);
    bus.mac_done = 1'b1;
    @(negedge clk);
    check("done_pulse", bus.done, 1);
    check("busy_fall", bus.busy, 0);
    check("mac_start_fall", bus.mac_start, 0);
    repeat (extra_done) @(negedge clk);
    bus.mac_done = 1'b0;
    if (extra_done == 0) @(negedge clk);
    repeat (3) begin
      check("done_low_after", bus.done, 0);
      check("busy_low_after", bus.busy, 0);
      @(negedge clk);
    end
    check("one_done_pulse", n_done - base, 1);
  endtask

  task automatic check_c(input string tag);
    for (int idx = 0; idx < M*N; idx++) begin
      bus.host_raddr = idx[3:0];
      @(negedge clk);
      check(tag, bus.host_rdata, c_ref(idx));
      c_prev[idx] = c_ref(idx);
    end
  endtask

  initial begin
    int base;
    rstn = 1'b0;
    bus.host_we = 1'b0; bus.host_sel = 1'b0; bus.host_waddr = '0; bus.host_wdata = '0;
    bus.host_raddr = '0; bus.go = 1'b0; bus.a_b_re = 1'b0; bus.a_addr = '0; bus.b_addr = '0;
    bus.c_we = 1'b0; bus.c_addr = '0; bus.c_data = '0; bus.mac_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mac_start", bus.mac_start, 0);
    check("rst_a_data", bus.a_data, 0);
    check("rst_b_data", bus.b_data, 0);
    check("rst_host_rdata", bus.host_rdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Identity A, B all 2
    for (int x = 0; x < M*K; x++) ref_a[x] = ((x / K) == (x % K)) ? 1 : 0;
    for (int x = 0; x < K*N; x++) ref_b[x] = 2;
    load_all();
    start_run();
    mac_run(0);
    check_c("c_identity");
    check("c0_is_2", c_prev[0], 2);

    // c_we outside RUN is ignored
    bus.c_we = 1'b1; bus.c_addr = 4'd3; bus.c_data = 16'hBEEF;
    @(negedge clk);
    bus.c_we = 1'b0;
    check_c("c_we_idle_ignored");

    // a_b_re low holds read data
    bus.a_b_re = 1'b1; bus.a_addr = 4'd5; bus.b_addr = 4'd6;
    @(negedge clk);
    bus.a_b_re = 1'b0; bus.a_addr = 4'd0; bus.b_addr = 4'd1;
    @(negedge clk);
    check("a_hold", bus.a_data, ref_a[5]);
    check("b_hold", bus.b_data, ref_b[6]);

    // All 255 wraps modulo 2^16
    for (int x = 0; x < M*K; x++) ref_a[x] = 255;
    for (int x = 0; x < K*N; x++) ref_b[x] = 255;
    load_all();
    start_run();
    mac_run(0);
    check_c("c_all255");
    check("c0_is_63492", c_prev[0], 63492);

    // Host write and second go during RUN are ignored
    for (int x = 0; x < M*K; x++) ref_a[x] = ((x / K) == (x % K)) ? 1 : 0;
    for (int x = 0; x < K*N; x++) ref_b[x] = $urandom_range(0, 255);
    load_all();
    start_run();
    bus.host_we = 1'b1; bus.host_sel = 1'b0; bus.host_waddr = 4'd0; bus.host_wdata = 8'd7;
    bus.go = 1'b1;
    @(negedge clk);
    bus.host_we = 1'b0; bus.go = 1'b0;
    mac_run(0);
    check_c("c_run_write_ignored");
    bus.a_b_re = 1'b1; bus.a_addr = 4'd0;
    @(negedge clk);
    bus.a_b_re = 1'b0;
    check("a0_unchanged", bus.a_data, 1);

    // Randomized runs with read-before-write probe
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < M*K; x++) ref_a[x] = $urandom_range(0, 255);
      for (int x = 0; x < K*N; x++) ref_b[x] = $urandom_range(0, 255);
      load_all();
      start_run();
      bus.host_raddr = 4'd2;
      bus.c_we = 1'b1; bus.c_addr = 4'd2; bus.c_data = 16'h1234;
      @(negedge clk);
      bus.c_we = 1'b0;
      check("rbw_old", bus.host_rdata, c_prev[2]);
      @(negedge clk);
      check("rbw_new", bus.host_rdata, 32'h1234);
      mac_run(0);
      check_c("c_random");
    end

    // Reset mid-RUN
    base = n_done;
    start_run();
    repeat (9) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_run_mac_start", bus.mac_start, 0);
    check("rst_run_busy", bus.busy, 0);
    check("rst_run_done", bus.done, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_no_done", n_done - base, 0);
    bus.a_b_re = 1'b1; bus.a_addr = 4'd3; bus.b_addr = 4'd9;
    @(negedge clk);
    bus.a_b_re = 1'b0;
    check("a_retained", bus.a_data, ref_a[3]);
    check("b_retained", bus.b_data, ref_b[9]);

    // host_we and go together in IDLE
    for (int x = 0; x < M*K; x++) ref_a[x] = $urandom_range(0, 255);
    for (int x = 0; x < K*N; x++) ref_b[x] = $urandom_range(0, 255);
    ref_a[5] = 0;
    load_all();
    bus.host_we = 1'b1; bus.host_sel = 1'b0; bus.host_waddr = 4'd5; bus.host_wdata = 8'd3;
    bus.go = 1'b1;
    ref_a[5] = 3;
    @(negedge clk);
    bus.host_we = 1'b0; bus.go = 1'b0;
    check("we_go_busy", bus.busy, 1);
    mac_run(0);
    check_c("c_we_go");

    // mac_done held past DONE into IDLE
    start_run();
    mac_run(2);
    check("idle_after_long_done", bus.busy, 0);
    check_c("c_long_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
